// File: rtl/obc_shift_accumulator.sv
// -----------------------------------------------------------------------------
// obc_shift_accumulator
//
// Shift-accumulator that sits behind the OBC coefficient ROM bank in the
// 16-point DFT datapath. It converts one output word per conversion.
//
// Each cycle the four ROM words for the current bit plane are summed into a
// partial sum P. P is accumulated LSB-first with a right shift per plane. On
// the sign-bit plane P is subtracted instead, and the OBC offset term is added.
// The result is narrowed to ROM_W bits.
//
// Parameters
//   DATA_W  bit planes per conversion (sample word width, >= 2)
//   ROM_W   ROM word width and result width
//   ACC_W   accumulator width, >= ROM_W+3
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset; aborts a running conversion
//   start         one-cycle pulse; accepted only while idle
//   offset_in     signed OBC offset, latched when start is accepted
//   rom_in0..3    signed ROM words for the presented bit_sel (combinational)
//   bit_sel       bit-plane index to the upstream slicer (0 = LSB, 0 in idle)
//   busy          high from the accepted start until the result is written
//   result        signed output word, held until the next conversion ends
//   result_valid  one-cycle pulse on the edge that updates result
//
// Build option
//   OBC_ACC_SAT_EN  defined:   the final sum clamps to the signed ROM_W range
//                   undefined: the final sum wraps (low ROM_W bits)
// -----------------------------------------------------------------------------
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_IDLE  | waiting for start; bit_sel held at 0, busy low
// ST_ACCUM | one cycle per bit plane; last plane writes result and returns
//
module obc_shift_accumulator #(
  parameter int DATA_W = 8,
  parameter int ROM_W  = 32,
  parameter int ACC_W  = 35
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic signed [ROM_W-1:0]   offset_in,
  input  logic signed [ROM_W-1:0]   rom_in0,
  input  logic signed [ROM_W-1:0]   rom_in1,
  input  logic signed [ROM_W-1:0]   rom_in2,
  input  logic signed [ROM_W-1:0]   rom_in3,
  output logic [$clog2(DATA_W)-1:0] bit_sel,
  output logic                      busy,
  output logic signed [ROM_W-1:0]   result,
  output logic                      result_valid
);

  localparam int SEL_W = $clog2(DATA_W);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(DATA_W - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [SEL_W-1:0]         bit_sel_q, bit_sel_d;
  logic                     busy_q, busy_d;
  logic signed [ROM_W-1:0]  result_q, result_d;
  logic                     result_valid_q, result_valid_d;
  logic signed [ROM_W-1:0]  offset_q, offset_d;

  function automatic logic signed [ACC_W-1:0] sext_rom(input logic signed [ROM_W-1:0] w);
    return {{(ACC_W-ROM_W){w[ROM_W-1]}}, w};
  endfunction

  // Partial sum of the four ROM words for the plane currently on bit_sel.
  logic signed [ACC_W-1:0] p_sum;
  assign p_sum = sext_rom(rom_in0) + sext_rom(rom_in1)
               + sext_rom(rom_in2) + sext_rom(rom_in3);

  // acc + P can exceed ACC_W by one bit before the halving, so the add is done
  // one bit wider. Dropping the LSB of the wide sum is exactly the arithmetic
  // right shift by one (floor), and the halved value always fits back in ACC_W.
  logic signed [ACC_W:0]   acc_ext, p_ext, acc_sum;
  logic signed [ACC_W-1:0] acc_plane;

  assign acc_ext   = {acc_q[ACC_W-1], acc_q};
  assign p_ext     = {p_sum[ACC_W-1], p_sum};
  assign acc_sum   = acc_ext + p_ext;
  assign acc_plane = acc_sum[ACC_W:1];

  // Final value on the sign-bit plane: acc - P + offset, narrowed to ROM_W.
  logic signed [ROM_W-1:0] res_final;

`ifdef OBC_ACC_SAT_EN
  localparam logic signed [ACC_W:0] RES_MAX = {{(ACC_W-ROM_W+2){1'b0}}, {(ROM_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] RES_MIN = {{(ACC_W-ROM_W+2){1'b1}}, {(ROM_W-1){1'b0}}};

  logic signed [ACC_W:0] off_ext, fin_sum;

  // One extra bit keeps acc - P + offset exact before the range check.
  assign off_ext = {{(ACC_W+1-ROM_W){offset_q[ROM_W-1]}}, offset_q};
  assign fin_sum = acc_ext - p_ext + off_ext;

  always_comb begin
    res_final = fin_sum[ROM_W-1:0];
    if (fin_sum > RES_MAX) begin
      res_final = {1'b0, {(ROM_W-1){1'b1}}};
    end else if (fin_sum < RES_MIN) begin
      res_final = {1'b1, {(ROM_W-1){1'b0}}};
    end
  end
`else
  // Wrapping only needs the low ROM_W bits, and those are unaffected by the
  // upper accumulator bits, so the subtraction is done at ROM_W width.
  assign res_final = acc_q[ROM_W-1:0] - p_sum[ROM_W-1:0] + offset_q;
`endif

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    bit_sel_d      = bit_sel_q;
    busy_d         = busy_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    offset_d       = offset_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          offset_d  = offset_in;
          acc_d     = '0;
          bit_sel_d = '0;
          busy_d    = 1'b1;
          state_d   = ST_ACCUM;
        end
      end

      ST_ACCUM: begin
        if (bit_sel_q == LAST_SEL) begin
          // A start seen on this edge is dropped: state is still ACCUM here.
          result_d       = res_final;
          result_valid_d = 1'b1;
          busy_d         = 1'b0;
          bit_sel_d      = '0;
          state_d        = ST_IDLE;
        end else begin
          acc_d     = acc_plane;
          bit_sel_d = bit_sel_q + 1'b1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        bit_sel_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      acc_q          <= '0;
      bit_sel_q      <= '0;
      busy_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      offset_q       <= '0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      bit_sel_q      <= bit_sel_d;
      busy_q         <= busy_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      offset_q       <= offset_d;
    end
  end

  assign bit_sel      = bit_sel_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_obc_shift_accumulator.sv
// -----------------------------------------------------------------------------
// tb_obc_shift_accumulator
//
// Bench for obc_shift_accumulator with DATA_W=8, ROM_W=32, ACC_W=35. The ROM
// bank is modelled as a table indexed by bit_sel. The expected result is
// computed in closed form: the seven magnitude planes are weighted by 2^k,
// floored by 2^7, then the sign plane is subtracted and the offset is added.
// Define OBC_ACC_SAT_EN for both DUT and bench to check the saturating build.
// -----------------------------------------------------------------------------
module tb_obc_shift_accumulator;

  localparam int DATA_W = 8;
  localparam int ROM_W  = 32;
  localparam int ACC_W  = 35;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ROM_W-1:0]  offset_in;
  logic [ROM_W-1:0]  rom_in0, rom_in1, rom_in2, rom_in3;
  logic [2:0]        bit_sel;
  logic              busy;
  logic [ROM_W-1:0]  result;
  logic              result_valid;

  logic [ROM_W-1:0]  plane [DATA_W][4];

  int n_tests = 0;
  int n_fail  = 0;

  obc_shift_accumulator #(
    .DATA_W(DATA_W),
    .ROM_W (ROM_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .offset_in   (offset_in),
    .rom_in0     (rom_in0),
    .rom_in1     (rom_in1),
    .rom_in2     (rom_in2),
    .rom_in3     (rom_in3),
    .bit_sel     (bit_sel),
    .busy        (busy),
    .result      (result),
    .result_valid(result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rom_in0 = plane[bit_sel][0];
  assign rom_in1 = plane[bit_sel][1];
  assign rom_in2 = plane[bit_sel][2];
  assign rom_in3 = plane[bit_sel][3];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [ROM_W-1:0] model(input logic [ROM_W-1:0] off);
    longint weighted, acc, p_sign, fin;
    weighted = 0;
    for (int k = 0; k < DATA_W - 1; k++) begin
      for (int j = 0; j < 4; j++) begin
        weighted += longint'($signed(plane[k][j])) * (longint'(1) << k);
      end
    end
    acc = weighted >>> (DATA_W - 1);
    p_sign = 0;
    for (int j = 0; j < 4; j++) p_sign += longint'($signed(plane[DATA_W-1][j]));
    fin = acc - p_sign + longint'($signed(off));
`ifdef OBC_ACC_SAT_EN
    if (fin > 64'sh7FFFFFFF) fin = 64'sh7FFFFFFF;
    if (fin < -64'sh80000000) fin = -64'sh80000000;
`endif
    return fin[ROM_W-1:0];
  endfunction

  task automatic clear_planes();
    for (int k = 0; k < DATA_W; k++)
      for (int j = 0; j < 4; j++)
        plane[k][j] = '0;
  endtask

  task automatic const_planes();
    clear_planes();
    for (int k = 0; k < DATA_W; k++) plane[k][0] = 32'h0000_0100;
  endtask

  // One conversion. smask[c] drives start during the cycle after edge c
  // (sampled at edge c+1); offset_in is scrambled whenever start is low.
  task automatic conv(input logic [ROM_W-1:0] off, input logic [31:0] smask,
                      input string tag, input logic [ROM_W-1:0] exp);
    int nvalid, nbusy, lat;
    nvalid = 0; nbusy = 0; lat = 0;
    @(posedge clk); #1;
    offset_in = off;
    start     = 1'b1;
    for (int c = 1; c <= 20 && nvalid == 0; c++) begin
      @(posedge clk); #1;
      start     = smask[c];
      offset_in = start ? off : $urandom;
      if (busy) nbusy++;
      check_val({tag, "_bitsel"}, {61'd0, bit_sel}, (c <= DATA_W) ? 64'(c - 1) : 64'd0);
      if (result_valid) begin
        nvalid++;
        lat = c;
      end
    end
    check_val({tag, "_latency"}, 64'(lat), 64'(DATA_W + 1));
    check_val({tag, "_busy_cycles"}, 64'(nbusy), 64'(DATA_W));
    check_val({tag, "_result"}, {32'd0, result}, {32'd0, exp});
    @(posedge clk); #1;
    check_val({tag, "_rv_pulse"}, {63'd0, result_valid}, 64'd0);
    check_val({tag, "_busy_after"}, {63'd0, busy}, {63'd0, smask[lat]});
    start = 1'b0;
  endtask

  // Wait for a conversion already in flight to finish.
  task automatic drain(input string tag, input logic [ROM_W-1:0] exp);
    logic found;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge clk); #1;
      offset_in = $urandom;
      if (result_valid) begin
        found = 1'b1;
        check_val({tag, "_result"}, {32'd0, result}, {32'd0, exp});
      end
    end
    check_val({tag, "_seen"}, {63'd0, found}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rv_seen;
    logic [ROM_W-1:0] off;
    logic [ROM_W-1:0] extremes [4];
    extremes[0] = 32'h7FFF_FFFF;
    extremes[1] = 32'h8000_0000;
    extremes[2] = 32'h0000_0000;
    extremes[3] = 32'hFFFF_FFFF;

    rst_n = 1'b0; start = 1'b0; offset_in = '0;
    clear_planes();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_bitsel", {61'd0, bit_sel}, 64'd0);
    check_val("rst_busy",   {63'd0, busy}, 64'd0);
    check_val("rst_result", {32'd0, result}, 64'd0);
    check_val("rst_rv",     {63'd0, result_valid}, 64'd0);
    @(negedge clk) rst_n = 1'b1;

    const_planes();
    conv(32'h0, 32'h0, "const", 32'hFFFF_FFFE);
    conv(32'h10, 32'h0, "const_off", 32'h0000_000E);

    clear_planes();
    plane[DATA_W-1][0] = 32'h0000_0100;
    conv(32'h0, 32'h0, "sign_only", 32'hFFFF_FF00);

    clear_planes();
    for (int j = 0; j < 4; j++) plane[0][j] = 32'h7FFF_FFFF;
`ifdef OBC_ACC_SAT_EN
    conv(32'h7FFF_FFFF, 32'h0, "overflow", 32'h7FFF_FFFF);
`else
    conv(32'h7FFF_FFFF, 32'h0, "overflow", 32'h83FF_FFFE);
`endif

    // Starts at cycles 3, 5 and on the result edge are ignored; the start held
    // into the following cycle begins a second conversion.
    const_planes();
    conv(32'h0, 32'h0000_0328, "proto", 32'hFFFF_FFFE);
    drain("proto_next", 32'hFFFF_FFFE);

    // Abort mid-conversion.
    const_planes();
    @(posedge clk); #1;
    start = 1'b1; offset_in = '0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 20 && bit_sel != 3'd4; c++) begin
      @(posedge clk); #1;
    end
    check_val("abort_reach", {61'd0, bit_sel}, 64'd4);
    #2 rst_n = 1'b0;
    #1;
    check_val("abort_bitsel", {61'd0, bit_sel}, 64'd0);
    check_val("abort_busy",   {63'd0, busy}, 64'd0);
    check_val("abort_result", {32'd0, result}, 64'd0);
    check_val("abort_rv",     {63'd0, result_valid}, 64'd0);
    rv_seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      rv_seen += int'(result_valid);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      rv_seen += int'(result_valid);
    end
    check_val("abort_no_rv", 64'(rv_seen), 64'd0);
    conv(32'h0, 32'h0, "after_abort", 32'hFFFF_FFFE);

    // Randomized planes and offsets against the closed-form model.
    for (int r = 0; r < 12; r++) begin
      int mode;
      mode = (r < 2) ? 2 : int'($urandom_range(0, 2));
      for (int k = 0; k < DATA_W; k++) begin
        for (int j = 0; j < 4; j++) begin
          case (mode)
            0:       plane[k][j] = $urandom;
            1:       plane[k][j] = 32'($urandom_range(0, 4095)) - 32'd2048;
            default: plane[k][j] = extremes[$urandom_range(0, 3)];
          endcase
        end
      end
      off = (mode == 1) ? 32'($urandom_range(0, 255)) - 32'd128 : $urandom;
      conv(off, 32'h0, "rnd", model(off));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/obc_shift_accumulator.md
Name: obc_shift_accumulator

Overview:
- Downstream consumer of the OBC coefficient ROM bank in the 16-point DFT datapath.
- Each cycle it takes the four 32-bit ROM words (1 sign, 10 integer, 21 fraction), adds them into a signed partial sum and shift-accumulates it, LSB-first, over DATA_W bit planes.
- It applies the OBC sign-bit subtraction and the offset term, then presents one 32-bit DFT output word.
- It also drives the bit-plane index to the upstream bit slicer, which generates the ROM select inputs.

Parameters:
- DATA_W, 8, sample word width = number of bit planes per conversion (min 2).
- ROM_W, 32, width of each ROM output word and of the result.
- ACC_W, 35, internal accumulator width; must be >= ROM_W+3.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a conversion when idle.
- offset_in  in  ROM_W  signed OBC offset term; latched on accepted start.
- rom_in0..rom_in3  in  ROM_W each  signed ROM words, valid combinationally for the current bit_sel.
- bit_sel  out  $clog2(DATA_W)  bit-plane index to the slicer (0 = LSB).
- busy  out  1  high from the accepted start until the result is written.
- result  out  ROM_W  signed DFT output; held until the next result.
- result_valid  out  1  one-cycle pulse when result updates.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, acc=0, bit_sel=0, busy=0, result=0, result_valid=0, offset register=0.
- Reset asserted mid-conversion aborts immediately. No result_valid is produced for the aborted conversion.
- States:
  - IDLE: start=1 latches offset_in, clears acc, sets bit_sel=0 and busy=1, goes to ACCUM.
  - ACCUM: lasts exactly DATA_W cycles, one per bit plane, bit_sel = 0..DATA_W-1.
  - Last ACCUM cycle returns to IDLE.
  - No other states.
- Partial sum P: all four rom_in words sign-extended to ACC_W and added. Sampled on the same edge that bit_sel is presented; ROM path is combinational, zero wait.
- Accumulation for bit_sel k < DATA_W-1: acc <= (acc + P) >>> 1. Arithmetic shift, truncation toward -inf, no rounding.
- Final cycle (k = DATA_W-1, sign bit): sum = acc - P + sext(offset).
  - result <= sum narrowed to ROM_W, wrap or saturate per SAT_EN.
  - result_valid <= 1 for exactly one cycle; busy <= 0 on the same edge.
- Latency: the start edge plus DATA_W edges, so result_valid is high DATA_W+1 clocks after the start edge (9 for DATA_W=8).
- start while busy: ignored; no queuing, no restart.
- start on the cycle busy falls (the edge that writes result) is also ignored. A new start is accepted from the following cycle, so back-to-back throughput is one conversion per DATA_W+1 cycles.
- bit_sel holds 0 in IDLE. rom_in values are don't-care in IDLE.
- result and result_valid change only on the final ACCUM edge or on reset.

Optional Feature:
- Macro: OBC_ACC_SAT_EN.
- Defined: the final sum is clamped to the signed ROM_W range, 0x7FFFFFFF / 0x80000000 for ROM_W=32.
- Undefined: the low ROM_W bits are taken, two's-complement wrap.
- Accumulation inside ACC_W is identical in both builds.

Test Plan:
- Constant plane sum: DATA_W=8, rom_in0=0x00000100 for every bit_sel, others 0, offset 0.
  - acc sequence 128,192,224,240,248,252,254.
  - Expect result=0xFFFFFFFE and result_valid exactly 9 clocks after start; busy high for 8 cycles.
- Same stimulus, offset_in=0x00000010 -> result=0x0000000E.
- Sign-bit only: rom_in0=0x00000100 only when bit_sel=7, else all 0 -> result=0xFFFFFF00.
- Overflow: all four rom_in=0x7FFFFFFF at bit_sel=0, 0 elsewhere, offset=0x7FFFFFFF.
  - Internal sum 0x83FFFFFE.
  - Expect result=0x7FFFFFFF with OBC_ACC_SAT_EN, 0x83FFFFFE without.
- Protocol: start pulsed at cycles 3 and 5 after the first start, then on the result_valid edge.
  - All three ignored; exactly one result_valid; bit_sel steps 0..7 once.
  - start one cycle after result_valid is accepted.
- Abort: drop rst_n at bit_sel=4.
  - All outputs go 0 asynchronously; no result_valid.
  - A fresh conversion after release gives the expected value from scenario 1.
